// File: rtl/conv_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_io_pkg
// Description : Shared types for the convolution input unit (FSM states,
//               PE beat format, prefetch FIFO entry).
// Revision    : 1.0 - initial release
// ============================================================================
package conv_io_pkg;

    localparam int BEAT_W = 49;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] addr;
        logic [15:0] data;
    } beat_t;

    // npix is 1 or 2; addr is the halfword address of the first pixel taken
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] addr;
        logic [1:0]  npix;
        logic        last;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage
`default_nettype wire

// File: rtl/conv_in_fifo.sv
`default_nettype none
// ============================================================================
// Module      : conv_in_fifo
// Description : Single-push/single-pop register FIFO exposing its fill count.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_in_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/conv_input_unit.sv
`default_nettype none
// ============================================================================
// Module      : conv_input_unit
// Description : Fetches a feature-map tile from 32-bit SRAM and streams 16-bit
//               pixels as {LAST, ADDR, DATA} beats. Optional macro
//               CONV_IN_PERF_CNT_EN adds the STALL_CYCLES counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_input_unit
    import conv_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              START,
    input  logic [31:0]       BASE_ADDR,
    input  logic [11:0]       ROW_LEN,
    input  logic [11:0]       ROW_CNT,
    input  logic [15:0]       ROW_STRIDE,
    output logic [ADDR_W-1:0] IADDR,
    output logic              IREAD,
    input  logic [31:0]       IRDATA,
    input  logic              STALL,
    output logic              input_valid,
    output logic [BEAT_W-1:0] input_value,
    output logic              BUSY,
    output logic              INPUTS_FINISH
`ifdef CONV_IN_PERF_CNT_EN
    ,
    output logic [31:0]       STALL_CYCLES
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t      r_state;
    state_t      w_next_state;

    logic [11:0] r_row_len;
    logic [11:0] r_row_cnt;
    logic [15:0] r_stride;
    logic [31:0] r_row_base;
    logic [11:0] r_col;
    logic [11:0] r_row;

    logic        r_pending;
    logic [31:0] r_pend_addr;
    logic [1:0]  r_pend_npix;
    logic        r_pend_last;
    logic        r_sub;

    logic              w_start_ok;
    logic              w_zero_tile;
    logic [31:0]       w_cur;
    logic [11:0]       w_remain;
    logic [1:0]        w_npix;
    logic              w_row_end;
    logic              w_last_read;
    logic [CW-1:0]     w_occ;
    logic              w_rd;
    logic [CW-1:0]     w_fifo_count;
    logic [ENTRY_W-1:0] w_fifo_head;
    fifo_entry_t       w_head;
    fifo_entry_t       w_push_entry;
    logic              w_valid;
    logic              w_final_pix;
    logic              w_xfer;
    logic              w_pop;
    logic              w_last_xfer;
    beat_t             w_beat;
    logic              w_unused;

    assign w_start_ok  = (r_state == IDLE) && START;
    assign w_zero_tile = (ROW_LEN == 12'd0) || (ROW_CNT == 12'd0);

    // An odd start takes only the upper half; words never straddle rows
    assign w_cur       = r_row_base + {20'd0, r_col};
    assign w_remain    = r_row_len - r_col;
    assign w_npix      = (w_cur[0] || (w_remain < 12'd2)) ? 2'd1 : 2'd2;
    assign w_row_end   = (r_col + {10'd0, w_npix}) == r_row_len;
    assign w_last_read = w_row_end && (r_row == (r_row_cnt - 12'd1));
    assign w_occ       = w_fifo_count + {{(CW-1){1'b0}}, r_pending};
    assign w_rd        = (r_state == FETCH) && (w_occ < CW'(FIFO_DEPTH));
    assign w_unused    = ^w_cur[31:ADDR_W+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_len  <= '0;
            r_row_cnt  <= '0;
            r_stride   <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_start_ok) begin
            r_row_len  <= ROW_LEN;
            r_row_cnt  <= ROW_CNT;
            r_stride   <= ROW_STRIDE;
            r_row_base <= BASE_ADDR;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_rd) begin
            if (w_row_end) begin
                r_col      <= '0;
                r_row_base <= r_row_base + {16'd0, r_stride};
                r_row      <= r_row + 12'd1;
            end else begin
                r_col <= r_col + {10'd0, w_npix};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_npix <= '0;
            r_pend_last <= 1'b0;
        end else begin
            r_pending <= w_rd;
            if (w_rd) begin
                r_pend_addr <= w_cur;
                r_pend_npix <= w_npix;
                r_pend_last <= w_last_read;
            end
        end
    end

    assign w_push_entry = '{word: IRDATA, addr: r_pend_addr,
                            npix: r_pend_npix, last: r_pend_last};

    conv_in_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_pending),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .count     (w_fifo_count)
    );

    assign w_head      = fifo_entry_t'(w_fifo_head);
    assign w_valid     = (w_fifo_count != '0);
    assign w_final_pix = (w_head.npix == 2'd1) || r_sub;
    assign w_xfer      = w_valid && !STALL;
    assign w_pop       = w_xfer && w_final_pix;
    assign w_last_xfer = w_pop && w_head.last;

    assign w_beat.addr = w_head.addr + {31'd0, r_sub};
    assign w_beat.data = w_beat.addr[0] ? w_head.word[31:16] : w_head.word[15:0];
    assign w_beat.last = w_head.last && w_final_pix;

    // r_sub selects the second pixel of a two-pixel entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub <= 1'b0;
        end else if (w_xfer) begin
            r_sub <= !w_final_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_next_state = w_zero_tile ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (w_rd && w_last_read) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_xfer && !r_pending && (w_fifo_count == CW'(1))) begin
                    w_next_state = FINISH;
                end
            end
            FINISH: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        IREAD         = w_rd;
        IADDR         = w_cur[ADDR_W:1];
        input_valid   = w_valid;
        input_value   = w_valid ? w_beat : '0;
        BUSY          = (r_state != IDLE) || w_start_ok;
        INPUTS_FINISH = (r_state == FINISH);
    end

`ifdef CONV_IN_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_stall_cycles <= '0;
        end else if (w_valid && STALL && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign STALL_CYCLES = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_input_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_input_unit
// Description : Directed scoreboard bench for conv_input_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_input_unit;
    import conv_io_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              START = 1'b0;
    logic [31:0]       BASE_ADDR = '0;
    logic [11:0]       ROW_LEN = '0;
    logic [11:0]       ROW_CNT = '0;
    logic [15:0]       ROW_STRIDE = '0;
    logic [ADDR_W-1:0] IADDR;
    logic              IREAD;
    logic [31:0]       IRDATA = '0;
    logic              STALL = 1'b0;
    logic              input_valid;
    logic [BEAT_W-1:0] input_value;
    logic              BUSY;
    logic              INPUTS_FINISH;
`ifdef CONV_IN_PERF_CNT_EN
    logic [31:0]       STALL_CYCLES;
`endif

    conv_input_unit #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .START         (START),
        .BASE_ADDR     (BASE_ADDR),
        .ROW_LEN       (ROW_LEN),
        .ROW_CNT       (ROW_CNT),
        .ROW_STRIDE    (ROW_STRIDE),
        .IADDR         (IADDR),
        .IREAD         (IREAD),
        .IRDATA        (IRDATA),
        .STALL         (STALL),
        .input_valid   (input_valid),
        .input_value   (input_value),
        .BUSY          (BUSY),
        .INPUTS_FINISH (INPUTS_FINISH)
`ifdef CONV_IN_PERF_CNT_EN
        ,
        .STALL_CYCLES  (STALL_CYCLES)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel at halfword h holds h - 0xFF, so word 0x80 = 0x0002_0001
    function automatic logic [15:0] hw(input logic [31:0] h);
        logic [31:0] t;
        t = h - 32'hFF;
        return t[15:0];
    endfunction

    always @(posedge clk) begin
        if (IREAD) IRDATA <= {hw({14'd0, IADDR, 1'b1}), hw({14'd0, IADDR, 1'b0})};
    end

    beat_t             exp_q[$];
    logic [ADDR_W-1:0] rd_q[$];

    bit          mon_en = 1'b0;
    bit          done_seen = 1'b0;
    bit          zero_tile = 1'b0;
    bit          prev_hold = 1'b0;
    bit          prev_fin = 1'b0;
    logic [48:0] prev_value = '0;
    int          acc_cyc = 0;
    int          last_cyc = -100;
    int          first_cyc = -1;
    int          beats_seen = 0;
    int          stall_reads = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (IREAD) begin
                if (STALL) stall_reads++;
                if (rd_q.size() == 0) check("unexpected_read", 64'(rd_q.size()), 64'd1);
                else check("iaddr", 64'(IADDR), 64'(rd_q.pop_front()));
            end
            if (prev_hold) begin
                check("stall_valid", 64'(input_valid), 64'd1);
                check("stall_value", 64'(input_value), 64'(prev_value));
            end
            if (input_valid && first_cyc < 0) first_cyc = cyc;
            if (input_valid && !STALL) begin
                if (exp_q.size() == 0) check("unexpected_beat", 64'(exp_q.size()), 64'd1);
                else check("beat", 64'(input_value), 64'(exp_q.pop_front()));
                if (input_value[48]) last_cyc = cyc;
                beats_seen++;
            end
            prev_hold  = input_valid && STALL;
            prev_value = input_value;
            if (INPUTS_FINISH) begin
                check("finish_pulse", 64'(prev_fin), 64'd0);
                check("finish_time", 64'(cyc), zero_tile ? 64'(acc_cyc) : 64'(last_cyc + 1));
                done_seen = 1'b1;
            end
            prev_fin = INPUTS_FINISH;
        end
    end

    task automatic build_expect(input logic [31:0] base, input int len, input int cnt,
                                input logic [15:0] stride);
        logic [31:0] rs;
        logic [31:0] h;
        beat_t       b;
        int          col;
        int          n;
        for (int r = 0; r < cnt; r++) begin
            rs = base + 32'(r) * {16'd0, stride};
            for (int c = 0; c < len; c++) begin
                b.addr = rs + 32'(c);
                b.data = hw(b.addr);
                b.last = (r == cnt - 1) && (c == len - 1);
                exp_q.push_back(b);
            end
            col = 0;
            while (col < len) begin
                h = rs + 32'(col);
                n = (h[0] || (len - col) < 2) ? 1 : 2;
                rd_q.push_back(h[ADDR_W:1]);
                col += n;
            end
        end
    endtask

    task automatic launch(input logic [31:0] base, input int len, input int cnt,
                          input logic [15:0] stride);
        build_expect(base, len, cnt, stride);
        zero_tile  = (len == 0) || (cnt == 0);
        done_seen  = 1'b0;
        first_cyc  = -1;
        last_cyc   = -100;
        beats_seen = 0;
        @(posedge clk); #1;
        BASE_ADDR  = base;
        ROW_LEN    = 12'(len);
        ROW_CNT    = 12'(cnt);
        ROW_STRIDE = stride;
        START      = 1'b1;
        @(negedge clk);
        check("busy_on_start", 64'(BUSY), 64'd1);
        @(posedge clk); #1;
        START   = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && !done_seen; i++) @(posedge clk);
        @(negedge clk);
        check("done_seen", 64'(done_seen), 64'd1);
        check("beats_left", 64'(exp_q.size()), 64'd0);
        check("reads_left", 64'(rd_q.size()), 64'd0);
        check("busy_after", 64'(BUSY), 64'd0);
        check("valid_after", 64'(input_valid), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(input_valid), 64'd0);
        check("rst_value", 64'(input_value), 64'd0);
        check("rst_iread", 64'(IREAD), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_finish", 64'(INPUTS_FINISH), 64'd0);
        mon_en = 1'b1;

        // Aligned single-row tile
        launch(32'h100, 4, 1, 16'd4);
        wait_done();
        check("first_beat_latency", 64'(first_cyc), 64'(acc_cyc + 2));

        // Odd start, two rows
        launch(32'h101, 3, 2, 16'd8);
        wait_done();
        check("odd_first_beat_latency", 64'(first_cyc), 64'(acc_cyc + 2));

        // Ten-cycle stall mid-tile
        launch(32'h200, 8, 3, 16'd16);
        for (int i = 0; i < 200 && beats_seen < 3; i++) @(posedge clk);
        #1;
        stall_reads = 0;
        STALL = 1'b1;
        repeat (10) @(posedge clk);
        #1 STALL = 1'b0;
        check("stall_reads_bounded", 64'(stall_reads <= FIFO_DEPTH), 64'd1);
        wait_done();
`ifdef CONV_IN_PERF_CNT_EN
        check("stall_cycles", 64'(STALL_CYCLES), 64'd10);
`endif

        // Empty tile
        launch(32'h300, 0, 5, 16'd4);
        check("zero_busy", 64'(BUSY), 64'd1);
        check("zero_finish", 64'(INPUTS_FINISH), 64'd1);
        wait_done();

        // START while busy is ignored
        launch(32'h400, 6, 2, 16'd6);
        repeat (3) @(posedge clk);
        #1;
        BASE_ADDR = 32'h500;
        ROW_LEN   = 12'd1;
        ROW_CNT   = 12'd1;
        START     = 1'b1;
        @(posedge clk); #1 START = 1'b0;
        wait_done();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("idle_after_ignore", 64'(input_valid), 64'd0);

        // Reset mid-FETCH, then a clean tile
        launch(32'h600, 12, 4, 16'd12);
        for (int i = 0; i < 200 && beats_seen < 2; i++) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        rd_q.delete();
        prev_hold = 1'b0;
        prev_fin  = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(input_valid), 64'd0);
        check("post_rst_busy", 64'(BUSY), 64'd0);
        check("post_rst_iread", 64'(IREAD), 64'd0);
        launch(32'h600, 5, 2, 16'd6);
        wait_done();
        check("post_rst_latency", 64'(first_cyc), 64'(acc_cyc + 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
